// File: rtl/symbol_source_pkg.sv
// symbol_source_pkg: shared widths, mapper levels and LFSR helpers for the symbol path
package symbol_source_pkg;

    localparam int LFSR_W = 22;
    localparam int MAP_W  = 18;
    localparam int IDX_W  = 4;

    localparam logic [LFSR_W-1:0] SEED_DEFAULT = 22'h3FFFFF;

    // Four-level amplitude alphabet, shared with the slicer and MER blocks
    localparam logic signed [MAP_W-1:0] LVL_N3 = 18'sh20000;
    localparam logic signed [MAP_W-1:0] LVL_N1 = -18'sd43691;
    localparam logic signed [MAP_W-1:0] LVL_P1 = 18'sd43690;
    localparam logic signed [MAP_W-1:0] LVL_P3 = 18'sd131071;

    // One step of the x^22+x^21+1 Fibonacci register
    function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] s);
        return {s[LFSR_W-2:0], s[LFSR_W-1] ^ s[LFSR_W-2]};
    endfunction

endpackage

// File: rtl/symbol_source_qam_axis_map.sv
// qam_axis_map: Gray-coded 2-bit to four-level amplitude mapping for one axis
module qam_axis_map
    import symbol_source_pkg::*;
(
    input  logic [1:0]              bits_i,
    output logic signed [MAP_W-1:0] level_o
);

    // Gray order along the axis: 00, 01, 11, 10 from most negative to most positive
    always_comb level_o = bits_i[1] ? (bits_i[0] ? LVL_P1 : LVL_P3)
                                    : (bits_i[0] ? LVL_N1 : LVL_N3);

endmodule

// File: rtl/symbol_source.sv
// symbol_source: LFSR or ramp symbol generator feeding a registered Gray-coded 4x4 mapper
module symbol_source
    import symbol_source_pkg::*;
#(
    parameter logic [LFSR_W-1:0] SEED         = SEED_DEFAULT,
    parameter bit                PERIOD_CHECK = 1'b1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    sym_clk_en,
    input  logic                    hold,
    input  logic                    test_mode,
    output logic signed [MAP_W-1:0] map_out_i,
    output logic signed [MAP_W-1:0] map_out_q,
    output logic [IDX_W-1:0]        sym_idx,
    output logic                    sym_valid,
    output logic                    clear_accum,
    output logic [LFSR_W-1:0]       lfsr_state
);

    logic [LFSR_W-1:0]       lfsr_q, lfsr_d, lfsr_nxt;
    logic [IDX_W-1:0]        ramp_q, ramp_d;
    logic [IDX_W-1:0]        sym_idx_q, sym_idx_d;
    logic signed [MAP_W-1:0] map_i_q, map_q_q, map_i_d, map_q_d;
    logic                    valid_q, valid_d;
    logic                    clear_q, clear_d;
    logic                    qual, adv, ramp_step, lockup;

    // Enable qualification, sequence next-state and the wrap detector
    always_comb begin
        qual      = sym_clk_en & ~hold;
        adv       = qual & ~test_mode;
        ramp_step = qual & test_mode;
        lockup    = lfsr_q == '0;
        lfsr_nxt  = lfsr_step(lfsr_q);
        lfsr_d    = lockup ? SEED : (adv ? lfsr_nxt : lfsr_q);
        ramp_d    = ramp_step ? ramp_q + 4'd1 : ramp_q;
        sym_idx_d = adv ? lfsr_q[IDX_W-1:0] : (ramp_step ? ramp_q : sym_idx_q);
        valid_d   = qual;
        clear_d   = PERIOD_CHECK && adv && !lockup && (lfsr_nxt == SEED);
    end

    // Map the index being loaded so levels and index land on the same edge
    qam_axis_map u_map_i (.bits_i(sym_idx_d[1:0]), .level_o(map_i_d));
    qam_axis_map u_map_q (.bits_i(sym_idx_d[3:2]), .level_o(map_q_d));

    // State and output registers; reset returns everything to the seed point
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lfsr_q    <= SEED;
            ramp_q    <= '0;
            sym_idx_q <= '0;
            map_i_q   <= LVL_N3;
            map_q_q   <= LVL_N3;
            valid_q   <= 1'b0;
            clear_q   <= 1'b0;
        end else begin
            lfsr_q    <= lfsr_d;
            ramp_q    <= ramp_d;
            sym_idx_q <= sym_idx_d;
            map_i_q   <= qual ? map_i_d : map_i_q;
            map_q_q   <= qual ? map_q_d : map_q_q;
            valid_q   <= valid_d;
            clear_q   <= clear_d;
        end
    end

    assign map_out_i   = map_i_q;
    assign map_out_q   = map_q_q;
    assign sym_idx     = sym_idx_q;
    assign sym_valid   = valid_q;
    assign clear_accum = clear_q;
    assign lfsr_state  = lfsr_q;

endmodule

// File: doc/symbol_source.md
SYMBOL_SOURCE -- requirements
Module: symbol_source

Interface
REQ-001 Parameter SEED, default 22'h3FFFFF, is the LFSR reset/reload state and SHALL be non-zero.
REQ-002 Parameter PERIOD_CHECK, default 1, enables the clear_accum wrap pulse; 0 holds clear_accum low.
REQ-003 clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 sym_clk_en  input  1  symbol-rate clock enable, one clk cycle wide.
REQ-006 hold  input  1  freezes the sequence; enables are ignored while high.
REQ-007 test_mode  input  1  0 = LFSR symbols; 1 = 4-bit ramp symbols.
REQ-008 map_out_i  output  18 signed  in-phase mapper level, registered.
REQ-009 map_out_q  output  18 signed  quadrature mapper level, registered.
REQ-010 sym_idx  output  4  symbol index driving the current map outputs.
REQ-011 sym_valid  output  1  one-cycle pulse marking new map outputs.
REQ-012 clear_accum  output  1  one-cycle pulse at each LFSR sequence wrap.
REQ-013 lfsr_state  output  22  current LFSR register, for debug.

Function
REQ-014 The LFSR SHALL be 22-bit Fibonacci, polynomial x^22+x^21+1, period 4194303.
- Update: state <= {state[20:0], state[21]^state[20]}.
REQ-015 The LFSR SHALL advance only on an edge with sym_clk_en=1, hold=0 and test_mode=0 ("advance edge").
REQ-016 On an advance edge, sym_idx SHALL load the pre-advance state[3:0].
REQ-017 In test_mode, each qualified enable edge SHALL increment a 4-bit ramp counter, wrapping 15->0.
- sym_idx loads the pre-increment counter value.
- The LFSR holds.
REQ-018 The mapper SHALL be Gray-coded per axis, with I from sym_idx[1:0] and Q from sym_idx[3:2].
- 00 -> -131072
- 01 -> -43691
- 11 -> 43690
- 10 -> 131071
REQ-019 map_out_i, map_out_q and sym_valid SHALL be registered on the same edge as sym_idx.
- Latency is one clk from the qualifying enable edge to valid outputs.
REQ-020 sym_valid SHALL be high for exactly the one cycle after each qualified enable edge, and low otherwise.
REQ-021 While no qualified enable occurs, all map outputs SHALL hold their values.
REQ-022 clear_accum SHALL pulse for one cycle after an advance edge whose next state equals SEED.
- Exactly one pulse per 4194303 advance edges.
REQ-023 Switching test_mode SHALL NOT reload the LFSR or ramp; each resumes from its held value.
REQ-024 hold and sym_clk_en both high SHALL produce no advance and no sym_valid.
REQ-025 The all-zero lockup state SHALL be detected and the LFSR reloaded with SEED on the next edge.

Reset
REQ-026 On reset assertion, the following SHALL take their reset values immediately, independent of clk:
- LFSR = SEED
- ramp = 0
- sym_idx = 0
- map_out_i = map_out_q = -131072
- sym_valid = 0, clear_accum = 0
REQ-027 Reset asserted mid-sequence SHALL discard all progress; the first advance after release uses SEED.

Structure
REQ-028 The shared package SHALL hold the four level constants (LVL_N3, LVL_N1, LVL_P1, LVL_P3), LFSR width 22, and SEED default.
- These are reused by the slicer and MER blocks.
REQ-029 The Gray mapper SHALL be one combinational sub-module, qam_axis_map (2-bit in, 18-bit signed out), instantiated twice.

Verification
REQ-030 Reset, then enable edges every 16 clk: first sym_idx=4'hF gives I=43690, Q=43690; second sym_idx=4'hE gives I=131071, Q=43690.
REQ-031 Run 4194303 advance edges from reset: exactly one clear_accum pulse, on the final edge; lfsr_state returns to 22'h3FFFFF.
REQ-032 test_mode=1 for 17 enables: sym_idx goes 0..15 then 0; at idx 5, I=-43691 and Q=-43691; lfsr_state is unchanged.
REQ-033 hold=1 with enables toggling for 100 cycles: no sym_valid, outputs and lfsr_state frozen.
REQ-034 Assert reset mid-edge after 1000 advances: outputs take reset values without a clk edge; the next advance repeats the REQ-030 sequence.
REQ-035 Force lfsr_state=0 via a bench override: reload to SEED within one clk, and no clear_accum is generated by the reload.
